// File: rtl/flag_status_if.sv
// Bus bundle for flag_status_unit: ALU result/flag-write inputs and NZCV flag outputs.
// master = ALU/control side driving results, slave = the flag unit.
interface flag_status_if #(
   parameter int WIDTH = 32
);
   logic             valid_in;
   logic [1:0]       op_class;
   logic             set_flags;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] result;
   logic             alu_carry;
   logic             shift_carry;
   logic             flag_wr_en;
   logic [3:0]       flag_wr_data;
   logic             save;
   logic             restore;
   logic             negative_flag;
   logic             zero_flag;
   logic             carry_flag;
   logic             overflow_flag;
   logic             flags_pending;
   logic             shadow_valid;

   modport master (
      output valid_in, op_class, set_flags, operand_a, operand_b, result,
             alu_carry, shift_carry, flag_wr_en, flag_wr_data, save, restore,
      input  negative_flag, zero_flag, carry_flag, overflow_flag,
             flags_pending, shadow_valid
   );

   modport slave (
      input  valid_in, op_class, set_flags, operand_a, operand_b, result,
             alu_carry, shift_carry, flag_wr_en, flag_wr_data, save, restore,
      output negative_flag, zero_flag, carry_flag, overflow_flag,
             flags_pending, shadow_valid
   );
endinterface

// File: rtl/flag_status_unit.sv
// NZCV flag producer: capture stage, then compute/commit into the architectural flag register.
// Define FLAG_SHADOW_EN to add a one-entry shadow copy for interrupt save/restore.
module flag_status_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   flag_status_if.slave bus
);
   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOGIC = 2'b10,
      OP_SHIFT = 2'b11
   } op_e;

   logic       r_s1_valid;
   logic       r_s2_valid;
   op_e        r_s1_op;
   logic       r_s1_a_msb;
   logic       r_s1_b_msb;
   logic       r_s1_r_msb;
   logic       r_s1_zero;
   logic       r_s1_alu_c;
   logic       r_s1_sh_c;
   logic [3:0] r_flags;

   logic       w_load;
   logic       w_restore;
   logic       w_flush;
   logic [3:0] w_shadow_flags;
   logic       w_c;
   logic       w_v;
   logic [3:0] w_next;
   logic       w_unused_bits;

   assign w_load  = bus.valid_in & bus.set_flags;
   assign w_flush = w_restore | bus.flag_wr_en;

   // Only the operand MSBs feed overflow detection.
   assign w_unused_bits = ^{bus.operand_a[WIDTH-2:0], bus.operand_b[WIDTH-2:0]};

`ifdef FLAG_SHADOW_EN
   logic [3:0] r_shadow;
   logic       r_shadow_valid;

   assign w_restore      = bus.restore;
   assign w_shadow_flags = r_shadow;

   // restore dominates save, so a simultaneous save never overwrites the shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow       <= '0;
         r_shadow_valid <= 1'b0;
      end else if (bus.restore) begin
         r_shadow_valid <= 1'b0;
      end else if (bus.save) begin
         r_shadow       <= r_flags;
         r_shadow_valid <= 1'b1;
      end
   end

   assign bus.shadow_valid = r_shadow_valid;
`else
   logic w_unused_shadow;

   assign w_unused_shadow  = bus.save ^ bus.restore;
   assign w_restore        = 1'b0;
   assign w_shadow_flags   = '0;
   assign bus.shadow_valid = 1'b0;
`endif

   always_comb begin
      w_c = r_flags[1];
      w_v = r_flags[0];
      case (r_s1_op)
         OP_ADD: begin
            w_c = r_s1_alu_c;
            w_v = (r_s1_a_msb == r_s1_b_msb) && (r_s1_r_msb != r_s1_a_msb);
         end
         OP_SUB: begin
            w_c = r_s1_alu_c;
            w_v = (r_s1_a_msb != r_s1_b_msb) && (r_s1_r_msb != r_s1_a_msb);
         end
         OP_SHIFT: w_c = r_s1_sh_c;
         default: ;
      endcase
      w_next = {r_s1_r_msb, r_s1_zero, w_c, w_v};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_op    <= OP_ADD;
         r_s1_a_msb <= 1'b0;
         r_s1_b_msb <= 1'b0;
         r_s1_r_msb <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_alu_c <= 1'b0;
         r_s1_sh_c  <= 1'b0;
      end else begin
         if (w_flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
         end else begin
            r_s1_valid <= w_load;
            r_s2_valid <= r_s1_valid;
         end
         if (w_load) begin
            r_s1_op    <= op_e'(bus.op_class);
            r_s1_a_msb <= bus.operand_a[WIDTH-1];
            r_s1_b_msb <= bus.operand_b[WIDTH-1];
            r_s1_r_msb <= bus.result[WIDTH-1];
            r_s1_zero  <= (bus.result == '0);
            r_s1_alu_c <= bus.alu_carry;
            r_s1_sh_c  <= bus.shift_carry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= '0;
      end else if (w_restore) begin
         r_flags <= w_shadow_flags;
      end else if (bus.flag_wr_en) begin
         r_flags <= bus.flag_wr_data;
      end else if (r_s1_valid) begin
         r_flags <= w_next;
      end
   end

   assign bus.negative_flag = r_flags[3];
   assign bus.zero_flag     = r_flags[2];
   assign bus.carry_flag    = r_flags[1];
   assign bus.overflow_flag = r_flags[0];
   assign bus.flags_pending = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_flag_status_unit.sv
// Scoreboard bench for flag_status_unit (WIDTH=8): stimulus queues expected flag state per cycle,
// a negedge monitor pops and compares. Shadow expectations follow FLAG_SHADOW_EN.
module tb_flag_status_unit;
   typedef struct {
      int unsigned tgt;
      string       name;
      logic [3:0]  flags;
      logic        pend;
      logic        shv;
   } exp_t;

`ifdef FLAG_SHADOW_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   exp_t        q[$];

   flag_status_if #(.WIDTH(8)) bus ();

   flag_status_unit #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].tgt <= cyc) begin
         exp_t e;
         logic [3:0] got;
         e   = q.pop_front();
         got = {bus.negative_flag, bus.zero_flag, bus.carry_flag, bus.overflow_flag};
         n_cmp++;
         if (e.tgt < cyc) begin
            n_bad++;
            $display("FAIL %s: check missed at cycle %0d, required cycle %0d", e.name, cyc, e.tgt);
         end else if (got !== e.flags || bus.flags_pending !== e.pend || bus.shadow_valid !== e.shv) begin
            n_bad++;
            $display("FAIL %s: got NZCV=%b pend=%b shv=%b, want NZCV=%b pend=%b shv=%b",
                     e.name, got, bus.flags_pending, bus.shadow_valid, e.flags, e.pend, e.shv);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.valid_in     = 1'b0;
      bus.op_class     = 2'b00;
      bus.set_flags    = 1'b0;
      bus.operand_a    = '0;
      bus.operand_b    = '0;
      bus.result       = '0;
      bus.alu_carry    = 1'b0;
      bus.shift_carry  = 1'b0;
      bus.flag_wr_en   = 1'b0;
      bus.flag_wr_data = '0;
      bus.save         = 1'b0;
      bus.restore      = 1'b0;
   endtask

   task automatic set_op(input logic [1:0] opc, input logic sf, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r, input logic ac, input logic sc);
      bus.valid_in    = 1'b1;
      bus.op_class    = opc;
      bus.set_flags   = sf;
      bus.operand_a   = a;
      bus.operand_b   = b;
      bus.result      = r;
      bus.alu_carry   = ac;
      bus.shift_carry = sc;
   endtask

   task automatic exp(input int unsigned off, input string nm, input logic [3:0] f,
                      input logic p, input logic s);
      exp_t e;
      e.tgt   = cyc + off;
      e.name  = nm;
      e.flags = f;
      e.pend  = p;
      e.shv   = s;
      q.push_back(e);
   endtask

   initial begin
      clr();
      step();
      step();
      exp(0, "reset_state", 4'b0000, 1'b0, 1'b0);
      exp(1, "reset_idle", 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      step();

      // ADD overflow: 0x7F + 0x01
      exp(0, "add_pre", 4'b0000, 1'b0, 1'b0);
      exp(1, "add_s1", 4'b0000, 1'b1, 1'b0);
      exp(2, "add_commit", 4'b1001, 1'b1, 1'b0);
      exp(3, "add_drain", 4'b1001, 1'b0, 1'b0);
      set_op(2'b00, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
      step(); clr();
      repeat (4) step();

      // SUB equal then LOGIC retaining C/V
      exp(2, "sub_zero", 4'b0110, 1'b1, 1'b0);
      exp(3, "logic_keep_cv", 4'b1010, 1'b1, 1'b0);
      exp(4, "logic_drain", 4'b1010, 1'b0, 1'b0);
      set_op(2'b01, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
      step();
      set_op(2'b10, 1'b1, 8'h00, 8'h00, 8'hF0, 1'b0, 1'b0);
      step(); clr();
      repeat (4) step();

      // Back-to-back ADD, SHIFT, SUB
      exp(2, "b2b_add", 4'b0100, 1'b1, 1'b0);
      exp(3, "b2b_shift", 4'b0010, 1'b1, 1'b0);
      exp(4, "b2b_sub", 4'b0011, 1'b1, 1'b0);
      exp(5, "b2b_drain", 4'b0011, 1'b0, 1'b0);
      set_op(2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      set_op(2'b11, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1);
      step();
      set_op(2'b01, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
      step(); clr();
      repeat (4) step();

      // Same sequence, middle op without set_flags
      exp(2, "nos_add", 4'b0100, 1'b1, 1'b0);
      exp(3, "nos_hold", 4'b0100, 1'b1, 1'b0);
      exp(4, "nos_sub", 4'b0011, 1'b1, 1'b0);
      exp(5, "nos_drain", 4'b0011, 1'b0, 1'b0);
      set_op(2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      set_op(2'b11, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1);
      step();
      set_op(2'b01, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
      step(); clr();
      repeat (4) step();

      // Direct write overrides an in-flight ADD
      exp(1, "wr_inflight", 4'b0011, 1'b1, 1'b0);
      exp(2, "wr_wins", 4'b1010, 1'b0, 1'b0);
      exp(3, "wr_no_late", 4'b1010, 1'b0, 1'b0);
      set_op(2'b00, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
      step(); clr();
      bus.flag_wr_en = 1'b1; bus.flag_wr_data = 4'b1010;
      step(); clr();
      repeat (3) step();

      // Direct write in the same cycle as valid_in drops the op
      exp(1, "wr_same_cycle", 4'b0101, 1'b0, 1'b0);
      exp(2, "wr_drop_op", 4'b0101, 1'b0, 1'b0);
      set_op(2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      bus.flag_wr_en = 1'b1; bus.flag_wr_data = 4'b0101;
      step(); clr();
      repeat (3) step();

      // Shadow save / restore (ignored without FLAG_SHADOW_EN)
      exp(1, "sh_set", 4'b0110, 1'b0, 1'b0);
      exp(2, "sh_saved", 4'b0110, 1'b0, SH);
      exp(3, "sh_add_s1", 4'b0110, 1'b1, SH);
      exp(4, "sh_add_commit", 4'b1001, 1'b1, SH);
      exp(5, "sh_logic_s1", 4'b1001, 1'b1, SH);
      exp(6, "sh_restore", SH ? 4'b0110 : 4'b0101, SH ? 1'b0 : 1'b1, 1'b0);
      exp(7, "sh_after", SH ? 4'b0110 : 4'b0101, 1'b0, 1'b0);
      exp(8, "sh_wr", 4'b1111, 1'b0, 1'b0);
      exp(9, "sh_save_restore", SH ? 4'b0110 : 4'b1111, 1'b0, 1'b0);
      bus.flag_wr_en = 1'b1; bus.flag_wr_data = 4'b0110;
      step(); clr();
      bus.save = 1'b1;
      step(); clr();
      set_op(2'b00, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
      step(); clr();
      step();
      set_op(2'b10, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      step(); clr();
      bus.restore = 1'b1;
      step(); clr();
      step();
      bus.flag_wr_en = 1'b1; bus.flag_wr_data = 4'b1111;
      step(); clr();
      bus.save = 1'b1; bus.restore = 1'b1;
      step(); clr();
      repeat (3) step();

      // Reset while an op sits in stage 1
      exp(2, "rst_clear", 4'b0000, 1'b0, 1'b0);
      exp(3, "rst_no_late1", 4'b0000, 1'b0, 1'b0);
      exp(4, "rst_no_late2", 4'b0000, 1'b0, 1'b0);
      set_op(2'b00, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
      step(); clr();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();

      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: never checked, required cycle %0d", e.name, e.tgt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
